// File: rtl/d_mem_delay_timer_pkg.sv
// Shared types and constants for the data-memory driven delay timer.
//   state_t    : fetch/run sequencer states
//   DATA_W     : width of a data-memory word and of each counter stage
//   ADDR_W     : width of the data-memory address
//   N_STAGES   : number of cascaded counter stages (one preset word each)
//   fetch_addr : address of preset word idx relative to a base (wraps mod 2^ADDR_W)
package d_timer_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned N_STAGES = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    LOAD2,
    RUN
  } state_t;

  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] base,
                                                   input int unsigned       idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/d_mem_delay_timer_stage.sv
// timer_stage: one 8-bit presettable up-counter of the delay cascade.
//   clk, rst_n   : clock, asynchronous active-low reset (clears the count)
//   load_i       : overwrite the count with load_val_i this cycle
//   load_val_i   : value loaded while load_i is high
//   cin_i        : count enable / carry in from the previous stage
//   reload_val_i : value taken instead of wrapping when counting past 8'hFF
//   cout_o       : carry out, high when counting from the terminal value
module timer_stage
  import d_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic              cin_i,
  input  logic [DATA_W-1:0] reload_val_i,
  output logic              cout_o
);

  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cin_i) begin
      // The terminal count reloads the preset rather than wrapping to zero,
      // so each stage spans (256 - preset) carries in.
      cnt_d = (cnt_q == '1) ? reload_val_i : cnt_q + 1'b1;
    end
  end

  assign cout_o = cin_i & (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/d_mem_delay_timer.sv
// d_mem_delay_timer: fetches three delay presets from consecutive data-memory
// words, then runs a cascaded 3-stage counter and pulses tick once per period
// P = (256-p0)(256-p1)(256-p2) cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : level request; every cycle seen high (without stop) begins a fetch
//   stop       : abort to IDLE; wins over start
//   mem_addr   : data-memory read address (BASE_ADDR outside the fetch)
//   mem_data   : data-memory read data, same-cycle valid
//   busy       : high in every state except IDLE
//   tick       : one-cycle pulse at the end of each period
//   tick_count : (only with DTIMER_TICK_COUNT_EN) ticks since the last fetch, wraps
// Parameters: BASE_ADDR (address of preset 0), AUTO_RELOAD (1 periodic, 0 one-shot).
module d_mem_delay_timer
  import d_timer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'd0,
  parameter bit                AUTO_RELOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              tick
`ifdef DTIMER_TICK_COUNT_EN
  ,
  output logic [7:0]        tick_count
`endif
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] preset_q [N_STAGES];
  logic [DATA_W-1:0] preset_d [N_STAGES];
  logic [N_STAGES-1:0] load;
  logic [N_STAGES:0]   carry;

  // Stage 0 counts every RUN cycle; each later stage counts on the carry of
  // the one before it, so carry[N_STAGES] marks the last cycle of a period.
  assign carry[0] = (state_q == RUN);

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    timer_stage u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load[g]),
      .load_val_i   (mem_data),
      .cin_i        (carry[g]),
      .reload_val_i (preset_q[g]),
      .cout_o       (carry[g+1])
    );
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    load     = '0;
    mem_addr = BASE_ADDR;
    // A restart or abort in the same cycle swallows the tick.
    tick     = carry[N_STAGES] & ~stop & ~start;

    case (state_q)
      IDLE: if (start && !stop) state_d = LOAD0;
      LOAD0: begin
        mem_addr    = fetch_addr(BASE_ADDR, 0);
        load[0]     = 1'b1;
        preset_d[0] = mem_data;
        state_d     = LOAD1;
      end
      LOAD1: begin
        mem_addr    = fetch_addr(BASE_ADDR, 1);
        load[1]     = 1'b1;
        preset_d[1] = mem_data;
        state_d     = LOAD2;
      end
      LOAD2: begin
        mem_addr    = fetch_addr(BASE_ADDR, 2);
        load[2]     = 1'b1;
        preset_d[2] = mem_data;
        state_d     = RUN;
      end
      RUN: if (tick && !AUTO_RELOAD) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort and restart override the normal sequence in every active state.
    if (state_q != IDLE) begin
      if (stop)       state_d = IDLE;
      else if (start) state_d = LOAD0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < N_STAGES; i++) preset_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
    end
  end

`ifdef DTIMER_TICK_COUNT_EN
  logic [7:0] tick_count_q, tick_count_d;

  always_comb begin
    tick_count_d = tick_count_q;
    if (state_d == LOAD0) tick_count_d = '0;
    else if (tick)        tick_count_d = tick_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_count_q <= '0;
    else        tick_count_q <= tick_count_d;
  end

  assign tick_count = tick_count_q;
`endif

endmodule
